// File: rtl/branch_predictor.sv
// ---------------------------------------------------------------------------
// branch_predictor
//   IF-stage branch predictor. A bimodal table of 2-bit saturating counters
//   and a tagless target buffer, both indexed by PC[IDX_BITS+1:2]. The
//   EX-stage resolver trains the tables. After reset a sweep FSM clears
//   every entry, one per cycle, and then the predictor goes live.
//
//   Optional feature macro: BRANCH_GSHARE_EN
//     When defined, a global history register (ghr) of resolved outcomes is
//     XORed into the counter index (gshare). The target buffer and its
//     valid bits stay indexed by the plain PC index.
//     When undefined, the predictor is purely bimodal and HIST_BITS is unused.
//
// Ports
//   clk          in   clock, rising edge
//   reset        in   synchronous, active-high; restarts the clearing sweep
//   IF_PC        in   PC of the instruction being fetched
//   prediction   out  1 = predict taken
//   predPC       out  next fetch PC: target if predicted taken, else IF_PC+4
//   ready        out  1 = sweep finished, predictor live
//   EX_isBranch  in   update strobe: EX holds a resolved conditional branch
//   EX_PC        in   PC of the EX branch
//   EX_condFlag  in   resolved outcome, 1 = taken
//   EX_PC_IMM    in   resolved taken target of the EX branch
// ---------------------------------------------------------------------------
module branch_predictor #(
  parameter int DBITS     = 32,
  parameter int IDX_BITS  = 8,
  parameter int HIST_BITS = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DBITS-1:0] IF_PC,
  output logic             prediction,
  output logic [DBITS-1:0] predPC,
  output logic             ready,
  input  logic             EX_isBranch,
  input  logic [DBITS-1:0] EX_PC,
  input  logic             EX_condFlag,
  input  logic [DBITS-1:0] EX_PC_IMM
);

  localparam int ENTRIES = 1 << IDX_BITS;

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t              state_q, state_d;
  logic [IDX_BITS-1:0] ptr_q, ptr_d;

  // Table storage; cleared by the sweep rather than by reset.
  logic [1:0]          ctr_q   [ENTRIES];
  logic [DBITS-1:0]    tgt_q   [ENTRIES];
  logic                valid_q [ENTRIES];

  // Plain PC indices (target buffer) and counter indices (may be hashed).
  logic [IDX_BITS-1:0] lk_pidx, up_pidx, lk_cidx, up_cidx;

  assign lk_pidx = IF_PC[IDX_BITS+1:2];
  assign up_pidx = EX_PC[IDX_BITS+1:2];

  // Only the index bits of EX_PC take part in the update.
  logic unused_ex_pc;
  assign unused_ex_pc = ^{EX_PC[DBITS-1:IDX_BITS+2], EX_PC[1:0]};

`ifdef BRANCH_GSHARE_EN
  logic [HIST_BITS-1:0] ghr_q, ghr_d;
  logic [IDX_BITS-1:0]  ghr_ext;

  assign ghr_ext = IDX_BITS'(ghr_q);
  assign lk_cidx = lk_pidx ^ ghr_ext;
  // Update indexes with the history as it was before this outcome shifts in.
  assign up_cidx = up_pidx ^ ghr_ext;

  // History only records resolved branches, so it is never rolled back.
  always_comb begin
    ghr_d = ghr_q;
    if (state_q == ST_INIT) begin
      ghr_d = '0;
    end else if (EX_isBranch) begin
      ghr_d = {ghr_q[HIST_BITS-2:0], EX_condFlag};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ghr_q <= '0;
    end else begin
      ghr_q <= ghr_d;
    end
  end
`else
  logic [HIST_BITS-1:0] unused_hist;
  assign unused_hist = '0;
  assign lk_cidx     = lk_pidx;
  assign up_cidx     = up_pidx;
`endif

  // -------------------------------------------------------------------------
  // Lookup: purely combinational, sees the table before this edge's update.
  // -------------------------------------------------------------------------
  logic [DBITS-1:0] pc_plus4;
  assign pc_plus4 = IF_PC + DBITS'(4);
  assign ready    = (state_q == ST_RUN);

  always_comb begin
    prediction = 1'b0;
    predPC     = pc_plus4;
    if (state_q == ST_RUN) begin
      prediction = ctr_q[lk_cidx][1] & valid_q[lk_pidx];
      if (prediction) begin
        predPC = tgt_q[lk_pidx];
      end
    end
  end

  // -------------------------------------------------------------------------
  // Sweep / update control
  // -------------------------------------------------------------------------
  logic [1:0]          up_ctr_old;
  logic                ctr_we, val_we, tgt_we;
  logic [IDX_BITS-1:0] ctr_widx, val_widx;
  logic [1:0]          ctr_wdata;
  logic                val_wdata;

  assign up_ctr_old = ctr_q[up_cidx];

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    ctr_we    = 1'b0;
    ctr_widx  = ptr_q;
    ctr_wdata = 2'b01;
    val_we    = 1'b0;
    val_widx  = ptr_q;
    val_wdata = 1'b0;
    tgt_we    = 1'b0;
    case (state_q)
      ST_INIT: begin
        // Clear one entry per cycle to weakly-not-taken / invalid target.
        ctr_we = 1'b1;
        val_we = 1'b1;
        ptr_d  = ptr_q + IDX_BITS'(1);
        if (ptr_q == '1) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (EX_isBranch) begin
          ctr_we   = 1'b1;
          ctr_widx = up_cidx;
          if (EX_condFlag) begin
            ctr_wdata = (up_ctr_old == 2'b11) ? 2'b11 : up_ctr_old + 2'b01;
            tgt_we    = 1'b1;
            val_we    = 1'b1;
            val_widx  = up_pidx;
            val_wdata = 1'b1;
          end else begin
            ctr_wdata = (up_ctr_old == 2'b00) ? 2'b00 : up_ctr_old - 2'b01;
          end
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_INIT;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      if (ctr_we) ctr_q[ctr_widx]   <= ctr_wdata;
      if (val_we) valid_q[val_widx] <= val_wdata;
      if (tgt_we) tgt_q[up_pidx]    <= EX_PC_IMM;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// ---------------------------------------------------------------------------
// tb_branch_predictor
//   Directed self-checking bench for branch_predictor (default IDX_BITS=8).
//   Outputs are sampled shortly after the rising edge once inputs settle.
// ---------------------------------------------------------------------------
module tb_branch_predictor;

  logic        clk;
  logic        reset;
  logic [31:0] IF_PC;
  logic        prediction;
  logic [31:0] predPC;
  logic        ready;
  logic        EX_isBranch;
  logic [31:0] EX_PC;
  logic        EX_condFlag;
  logic [31:0] EX_PC_IMM;

  int checks = 0;
  int errors = 0;

  branch_predictor dut (
    .clk         (clk),
    .reset       (reset),
    .IF_PC       (IF_PC),
    .prediction  (prediction),
    .predPC      (predPC),
    .ready       (ready),
    .EX_isBranch (EX_isBranch),
    .EX_PC       (EX_PC),
    .EX_condFlag (EX_condFlag),
    .EX_PC_IMM   (EX_PC_IMM)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic update(input logic [31:0] pc, input logic flag, input logic [31:0] imm);
    EX_isBranch = 1'b1;
    EX_PC       = pc;
    EX_condFlag = flag;
    EX_PC_IMM   = imm;
    tick();
    EX_isBranch = 1'b0;
    $display("update pc=0x%08h taken=%0d imm=0x%08h", pc, flag, imm);
  endtask

  task automatic lookup(input string tag, input logic [31:0] pc,
                        input logic exp_pred, input logic [31:0] exp_pc);
    IF_PC = pc;
    #1;
    check({tag, "_pred"}, 32'(prediction), 32'(exp_pred));
    check({tag, "_pc"}, predPC, exp_pc);
    $display("lookup %s pc=0x%08h pred=%0d predPC=0x%08h", tag, pc, prediction, predPC);
  endtask

  // Expects the sweep to have just started (state INIT, ptr 0).
  task automatic sweep(input string tag, input logic [31:0] exp_pc);
    for (int i = 0; i < 256; i++) begin
      check({tag, "_ready0"}, 32'(ready), 32'd0);
      check({tag, "_pc"}, predPC, exp_pc);
      tick();
    end
    check({tag, "_ready1"}, 32'(ready), 32'd1);
    $display("sweep %s done ready=%0d", tag, ready);
  endtask

  initial begin
    reset       = 1'b1;
    IF_PC       = 32'h100;
    EX_isBranch = 1'b0;
    EX_PC       = 32'h0;
    EX_condFlag = 1'b0;
    EX_PC_IMM   = 32'h0;
    tick();
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_pred", 32'(prediction), 32'd0);
    check("rst_pc", predPC, 32'h104);
    $display("reset ready=%0d pred=%0d predPC=0x%08h", ready, prediction, predPC);

    // Sweep with a taken update held active: all of it must be dropped.
    reset       = 1'b0;
    EX_isBranch = 1'b1;
    EX_PC       = 32'h40;
    EX_condFlag = 1'b1;
    EX_PC_IMM   = 32'h80;
    sweep("sweep1", 32'h104);
    EX_isBranch = 1'b0;
    lookup("init_drop", 32'h40, 1'b0, 32'h44);

`ifdef BRANCH_GSHARE_EN
    // Taken on 0x40 with ghr=0 trains counter idx 0x10; ghr becomes 1 so
    // the next lookup of 0x40 hits untrained counter idx 0x11.
    update(32'h40, 1'b1, 32'h80);
    lookup("gs_hash", 32'h40, 1'b0, 32'h44);
`else
    // Single taken update: 01 -> 10.
    update(32'h40, 1'b1, 32'h80);
    lookup("t2_hit", 32'h40, 1'b1, 32'h80);
    lookup("t2_miss", 32'h44, 1'b0, 32'h48);

    // Same-cycle lookup and update on 0x60: no bypass.
    IF_PC       = 32'h60;
    EX_isBranch = 1'b1;
    EX_PC       = 32'h60;
    EX_condFlag = 1'b1;
    EX_PC_IMM   = 32'h200;
    #1;
    check("t4_same_pred", 32'(prediction), 32'd0);
    check("t4_same_pc", predPC, 32'h64);
    $display("same-cycle pc=0x60 pred=%0d predPC=0x%08h", prediction, predPC);
    tick();
    EX_isBranch = 1'b0;
    lookup("t4_next", 32'h60, 1'b1, 32'h200);

    // Saturation high, then walk down to the floor.
    repeat (4) update(32'h40, 1'b1, 32'h80);
    lookup("t3_sat", 32'h40, 1'b1, 32'h80);
    update(32'h40, 1'b0, 32'h0);
    lookup("t3_nt1", 32'h40, 1'b1, 32'h80);
    update(32'h40, 1'b0, 32'h0);
    lookup("t3_nt2", 32'h40, 1'b0, 32'h44);
    repeat (3) update(32'h40, 1'b0, 32'h0);
    update(32'h40, 1'b1, 32'h80);
    lookup("t3_floor", 32'h40, 1'b0, 32'h44);
    update(32'h40, 1'b1, 32'h80);
    lookup("t3_up", 32'h40, 1'b1, 32'h80);

    // No strobe: state must hold even with a not-taken outcome present.
    EX_PC       = 32'h40;
    EX_condFlag = 1'b0;
    repeat (3) tick();
    lookup("hold", 32'h40, 1'b1, 32'h80);
`endif

    // predPC wraps modulo 2^32.
    lookup("wrap", 32'hFFFF_FFFC, 1'b0, 32'h0);

    // Reset in RUN, then again mid-sweep at ptr=100.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t5_run_rst", 32'(ready), 32'd0);
    IF_PC = 32'h100;
    repeat (100) tick();
    check("t5_mid_ready", 32'(ready), 32'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    sweep("t5_resweep", 32'h104);
    lookup("t5_clr40", 32'h40, 1'b0, 32'h44);
    lookup("t5_clr60", 32'h60, 1'b0, 32'h64);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
